fwd_scoreboard_unit: RTL and testbench

- Parametrised successor to the EX-stage forwarding unit.
- Owns a DEPTH-stage destination-tag pipeline that shadows the datapath stages after EX (stage 1 = MEM, stage 2 = WB, and further stages if deeper).
- Per source operand it produces a forward-select, and it raises load-use Stall when the producing stage's data is not yet available.
- Generalises the fixed 2-source, MEM/WB-only scheme to NUM_SRC sources, DEPTH stages and configurable load latency.

---
 rtl/fwd_pkg.sv | 26 ++
 rtl/fwd_scoreboard_unit_if.sv | 39 +++
 rtl/fwd_src_match.sv | 42 ++++
 rtl/fwd_scoreboard_unit.sv | 96 +++++++++
 tb/tb_fwd_scoreboard_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the EX-stage forwarding scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fwd_pkg;

    // Widest register address the tag can hold. Narrower REG_AW values are
    // zero-extended into the tag, so the unused upper bits are constant.
    localparam int FWD_RD_MAX_W = 8;

    // Forward-select value meaning "take the operand from the register file".
    localparam int FWD_SEL_RF = 0;

    // Destination tag carried by each tracked post-EX stage.
    typedef struct packed {
        logic                    v;   // stage holds a real instruction
        logic [FWD_RD_MAX_W-1:0] rd;  // destination register
        logic                    wr;  // writes the register file
        logic                    ld;  // is a load (data arrives late)
    } fwd_tag_t;

    // Width of one forward-select field: encodes 0 (RF) .. depth (stage).
    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_scoreboard_unit_if.sv
// EX-side bundle between the pipeline control and the forwarding scoreboard.
// Latency: n/a (wires only); the scoreboard answers combinationally.
// Backpressure: Stall_ext freezes the scoreboard; Stall asks upstream to hold.
// master: pipeline control (drives EX info, consumes Fwd_sel/Stall/Stall_cnt).
// slave : fwd_scoreboard_unit.
interface fwd_scoreboard_unit_if
    import fwd_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
);
    localparam int SEL_W = sel_w(DEPTH);

    logic                       Stall_ext;
    logic                       Flush;
    logic                       EX_valid;
    logic [REG_AW-1:0]          EX_rd;
    logic                       EX_RegWrite;
    logic                       EX_MemRead;
    logic [NUM_SRC*REG_AW-1:0]  EX_src;
    logic [NUM_SRC-1:0]         EX_src_used;
    logic [NUM_SRC*SEL_W-1:0]   Fwd_sel;
    logic                       Stall;
    logic [CNT_W-1:0]           Stall_cnt;

    modport master (
        output Stall_ext, Flush, EX_valid, EX_rd, EX_RegWrite, EX_MemRead,
               EX_src, EX_src_used,
        input  Fwd_sel, Stall, Stall_cnt
    );

    modport slave (
        input  Stall_ext, Flush, EX_valid, EX_rd, EX_RegWrite, EX_MemRead,
               EX_src, EX_src_used,
        output Fwd_sel, Stall, Stall_cnt
    );
endinterface

// File: rtl/fwd_src_match.sv
// Per-operand priority encoder: picks the youngest in-flight producer of src.
// Latency: combinational, zero cycles.
// Backpressure: none; need_stall flags a load whose data is not yet forwardable.
// Ports: src/used/ex_valid describe one EX operand, tags is the stage pipeline
// (index 1 = youngest), sel is 0 for RF or the stage number, need_stall is
// raised when the chosen producer is a load earlier than LOAD_READY_STAGE.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int REG_AW           = 5,
    parameter int DEPTH            = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = 2
) (
    input  logic [REG_AW-1:0]    src,
    input  logic                 used,
    input  logic                 ex_valid,
    input  fwd_tag_t [DEPTH:1]   tags,
    output logic [SEL_W-1:0]     sel,
    output logic                 need_stall
);

    logic found;

    always_comb begin
        sel        = SEL_W'(FWD_SEL_RF);
        need_stall = 1'b0;
        found      = 1'b0;
        // Scan youngest first; the first hit decides both sel and stall, so an
        // older ready producer can never hide a younger unready load.
        for (int k = 1; k <= DEPTH; k++) begin
            if (!found && ex_valid && used && (src != '0) &&
                tags[k].v && tags[k].wr &&
                (tags[k].rd == FWD_RD_MAX_W'(src))) begin
                found      = 1'b1;
                sel        = SEL_W'(k);
                need_stall = tags[k].ld && (k < LOAD_READY_STAGE);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding scoreboard: DEPTH-stage destination-tag shadow pipeline after EX,
// per-operand forward select and load-use stall.
// Latency: Fwd_sel/Stall combinational (zero cycles); tags advance one stage per edge.
// Backpressure: Stall_ext freezes all tags; Stall inserts a bubble into stage 1.
// Ports: Clk, Reset_n (async active-low), bus = fwd_scoreboard_unit_if.slave.
// Optional: define FWD_STALL_CNT_EN to build the saturating stall-cycle counter;
// otherwise Stall_cnt reads constant zero.
module fwd_scoreboard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW           = 5,
    parameter int NUM_SRC          = 2,
    parameter int DEPTH            = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int CNT_W            = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    fwd_scoreboard_unit_if.slave bus
);

    localparam int SEL_W = sel_w(DEPTH);

    if (REG_AW > FWD_RD_MAX_W) begin : g_rd_too_wide
        $error("REG_AW exceeds the register field of fwd_tag_t");
    end

    fwd_tag_t [DEPTH:1]          tags;
    fwd_tag_t                    ex_tag;
    logic [NUM_SRC-1:0]          need_stall;
    logic [NUM_SRC*SEL_W-1:0]    fwd_sel;
    logic                        stall;

    // A stalled or flushed EX instruction must not be tracked: it will either
    // be replayed next cycle or never write back.
    always_comb begin
        ex_tag = '0;
        if (bus.EX_valid && !stall && !bus.Flush) begin
            ex_tag.v  = 1'b1;
            ex_tag.rd = FWD_RD_MAX_W'(bus.EX_rd);
            ex_tag.wr = bus.EX_RegWrite;
            ex_tag.ld = bus.EX_MemRead;
        end
    end

    // Tag shift register; the oldest tag simply falls off stage DEPTH.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tags <= '0;
        end else if (!bus.Stall_ext) begin
            for (int k = DEPTH; k >= 2; k--) begin
                tags[k] <= tags[k-1];
            end
            tags[1] <= ex_tag;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(
            .REG_AW           (REG_AW),
            .DEPTH            (DEPTH),
            .LOAD_READY_STAGE (LOAD_READY_STAGE),
            .SEL_W            (SEL_W)
        ) u_match (
            .src        (bus.EX_src[i*REG_AW +: REG_AW]),
            .used       (bus.EX_src_used[i]),
            .ex_valid   (bus.EX_valid),
            .tags       (tags),
            .sel        (fwd_sel[i*SEL_W +: SEL_W]),
            .need_stall (need_stall[i])
        );
    end

    assign stall       = |need_stall;
    assign bus.Stall   = stall;
    assign bus.Fwd_sel = fwd_sel;

`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    // Counts edges on which the pipeline really lost a cycle to a load-use;
    // frozen cycles are not attributed to the hazard.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cnt <= '0;
        end else if (stall && !bus.Stall_ext && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.Stall_cnt = stall_cnt;
`else
    assign bus.Stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Bench for fwd_scoreboard_unit: a default instance (a) and a deep instance (b,
// DEPTH=4, LOAD_READY_STAGE=3, NUM_SRC=3) driven with directed vectors; an
// in-flight instruction model predicts outputs, compared every falling edge.
module tb_fwd_scoreboard_unit;

    logic Clk;
    logic Reset_n;

    fwd_scoreboard_unit_if #(.REG_AW(5), .NUM_SRC(2), .DEPTH(2), .CNT_W(16)) ia ();
    fwd_scoreboard_unit_if #(.REG_AW(5), .NUM_SRC(3), .DEPTH(4), .CNT_W(16)) ib ();

    fwd_scoreboard_unit #(
        .REG_AW(5), .NUM_SRC(2), .DEPTH(2), .LOAD_READY_STAGE(2), .CNT_W(16)
    ) u_a (
        .Clk(Clk), .Reset_n(Reset_n), .bus(ia)
    );

    fwd_scoreboard_unit #(
        .REG_AW(5), .NUM_SRC(3), .DEPTH(4), .LOAD_READY_STAGE(3), .CNT_W(16)
    ) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .bus(ib)
    );

    int total = 0;
    int bad   = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- model: in-flight instructions by age ----------------
    function automatic int dep_of(input int d);  return (d == 0) ? 2 : 4; endfunction
    function automatic int lrs_of(input int d);  return (d == 0) ? 2 : 3; endfunction
    function automatic int nsrc_of(input int d); return (d == 0) ? 2 : 3; endfunction

    // age 1 = instruction that left EX most recently
    bit mv  [2][8];
    int mrd [2][8];
    bit mwr [2][8];
    bit mld [2][8];
    int mcnt[2];

    function automatic void model_eval(input int d, output logic [2:0][2:0] sel_o,
                                       output bit stall_o);
        bit              ev;
        logic [2:0]      used;
        logic [2:0][4:0] src;
        if (d == 0) begin
            ev   = ia.EX_valid;
            used = {1'b0, ia.EX_src_used};
            src  = {5'd0, ia.EX_src};
        end else begin
            ev   = ib.EX_valid;
            used = ib.EX_src_used;
            src  = ib.EX_src;
        end
        sel_o   = '0;
        stall_o = 1'b0;
        for (int i = 0; i < nsrc_of(d); i++) begin
            if (ev && used[i] && src[i] != 5'd0) begin
                // walk oldest to youngest so the youngest writer is left standing
                for (int a = dep_of(d); a >= 1; a--)
                    if (mv[d][a] && mwr[d][a] && mrd[d][a] == int'(src[i]))
                        sel_o[i] = 3'(a);
                if (sel_o[i] != 3'd0 && mld[d][int'(sel_o[i])] && int'(sel_o[i]) < lrs_of(d))
                    stall_o = 1'b1;
            end
        end
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int d = 0; d < 2; d++) begin
                mcnt[d] = 0;
                for (int a = 0; a < 8; a++) begin
                    mv[d][a] = 0; mrd[d][a] = 0; mwr[d][a] = 0; mld[d][a] = 0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic [2:0][2:0] s;
                bit st, ext, fl, ev, wr, ld;
                int rd;
                model_eval(d, s, st);
                ext = (d == 0) ? ia.Stall_ext   : ib.Stall_ext;
                fl  = (d == 0) ? ia.Flush       : ib.Flush;
                ev  = (d == 0) ? ia.EX_valid    : ib.EX_valid;
                wr  = (d == 0) ? ia.EX_RegWrite : ib.EX_RegWrite;
                ld  = (d == 0) ? ia.EX_MemRead  : ib.EX_MemRead;
                rd  = (d == 0) ? int'(ia.EX_rd) : int'(ib.EX_rd);
                if (!ext) begin
                    for (int a = dep_of(d); a >= 2; a--) begin
                        mv[d][a] = mv[d][a-1]; mrd[d][a] = mrd[d][a-1];
                        mwr[d][a] = mwr[d][a-1]; mld[d][a] = mld[d][a-1];
                    end
                    mv[d][1]  = ev && !st && !fl;
                    mrd[d][1] = rd; mwr[d][1] = wr; mld[d][1] = ld;
`ifdef FWD_STALL_CNT_EN
                    if (st && mcnt[d] < 65535) mcnt[d] = mcnt[d] + 1;
`endif
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge Clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [2:0][2:0] s;
            bit st;
            model_eval(d, s, st);
            for (int i = 0; i < nsrc_of(d); i++) begin
                if (d == 0) check($sformatf("cyc a sel%0d", i), 64'(ia.Fwd_sel[i*2 +: 2]), 64'(s[i]));
                else        check($sformatf("cyc b sel%0d", i), 64'(ib.Fwd_sel[i*3 +: 3]), 64'(s[i]));
            end
            check($sformatf("cyc %0d stall", d), (d == 0) ? 64'(ia.Stall) : 64'(ib.Stall), 64'(st));
            check($sformatf("cyc %0d cnt", d), (d == 0) ? 64'(ia.Stall_cnt) : 64'(ib.Stall_cnt),
                  64'(mcnt[d]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_a(input bit v, input logic [4:0] rd, input bit wr, input bit ld,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
        ia.EX_valid = v; ia.EX_rd = rd; ia.EX_RegWrite = wr; ia.EX_MemRead = ld;
        ia.EX_src = {s1, s0}; ia.EX_src_used = used;
    endtask

    task automatic set_b(input bit v, input logic [4:0] rd, input bit wr, input bit ld,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] used);
        ib.EX_valid = v; ib.EX_rd = rd; ib.EX_RegWrite = wr; ib.EX_MemRead = ld;
        ib.EX_src = {s2, s1, s0}; ib.EX_src_used = used;
    endtask

    function automatic logic [1:0] a_sel(input int i);
        logic [3:0] f;
        f = ia.Fwd_sel;
        return f[i*2 +: 2];
    endfunction

    function automatic logic [2:0] b_sel(input int i);
        logic [8:0] f;
        f = ib.Fwd_sel;
        return f[i*3 +: 3];
    endfunction

    initial begin
        Reset_n = 1'b0;
        ia.Stall_ext = 0; ia.Flush = 0; ib.Stall_ext = 0; ib.Flush = 0;
        set_a(0, 0, 0, 0, 0, 0, 2'b00);
        set_b(0, 0, 0, 0, 0, 0, 0, 3'b000);
        #12 Reset_n = 1'b1;
        tick();

        // ---- reset while a load-use stall is showing ----
        set_a(1, 5'd9, 1, 1, 0, 0, 2'b00);
        tick();
        set_a(1, 5'd0, 0, 0, 5'd9, 0, 2'b01);
        #1;
        check("pre-reset stall", 64'(ia.Stall), 64'd1);
        check("pre-reset sel0", 64'(a_sel(0)), 64'd1);
        #1 Reset_n = 1'b0;
        #1;
        check("async reset stall", 64'(ia.Stall), 64'd0);
        check("async reset sel", 64'(ia.Fwd_sel), 64'd0);
        check("reset cnt", 64'(ia.Stall_cnt), 64'd0);
        set_a(0, 0, 0, 0, 0, 0, 2'b00);
        #3 Reset_n = 1'b1;
        tick();
        set_a(1, 5'd0, 0, 0, 5'd5, 5'd9, 2'b11);
        #1;
        check("post-reset sel0", 64'(a_sel(0)), 64'd0);
        check("post-reset sel1", 64'(a_sel(1)), 64'd0);
        tick();

        // ---- ALU chain ----
        set_a(1, 5'd5, 1, 0, 0, 0, 2'b00);
        tick();
        set_a(1, 5'd7, 1, 0, 5'd5, 0, 2'b01);
        #1 check("alu c1 sel0", 64'(a_sel(0)), 64'd1);
        tick();
        set_a(1, 5'd0, 0, 0, 5'd5, 5'd7, 2'b11);
        #1;
        check("alu c2 sel0", 64'(a_sel(0)), 64'd2);
        check("alu c2 sel1", 64'(a_sel(1)), 64'd1);
        tick();

        // ---- load-use ----
        set_a(1, 5'd8, 1, 1, 0, 0, 2'b00);
        tick();
        set_a(1, 5'd10, 1, 0, 5'd8, 0, 2'b01);
        #1;
        check("lu c1 stall", 64'(ia.Stall), 64'd1);
        check("lu c1 sel0", 64'(a_sel(0)), 64'd1);
        tick();
        #1;
        check("lu c2 stall", 64'(ia.Stall), 64'd0);
        check("lu c2 sel0", 64'(a_sel(0)), 64'd2);
`ifdef FWD_STALL_CNT_EN
        check("lu c2 cnt", 64'(ia.Stall_cnt), 64'd1);
`else
        check("lu c2 cnt", 64'(ia.Stall_cnt), 64'd0);
`endif
        tick();

        // ---- priority and r0 ----
        set_a(1, 5'd3, 1, 0, 0, 0, 2'b00);
        tick();
        set_a(1, 5'd3, 1, 0, 5'd3, 0, 2'b01);
        #1 check("prio one stage", 64'(a_sel(0)), 64'd1);
        tick();
        set_a(1, 5'd0, 1, 0, 5'd3, 0, 2'b01);
        #1 check("prio youngest", 64'(a_sel(0)), 64'd1);
        tick();
        set_a(1, 5'd0, 0, 0, 5'd0, 0, 2'b01);
        #1 check("r0 no fwd", 64'(a_sel(0)), 64'd0);
        tick();
        set_a(1, 5'd11, 1, 1, 0, 0, 2'b00);
        tick();
        set_a(1, 5'd0, 0, 0, 5'd11, 5'd11, 2'b00);
        #1;
        check("unused src stall", 64'(ia.Stall), 64'd0);
        check("unused src sel", 64'(ia.Fwd_sel), 64'd0);
        tick();

        // ---- freeze with flush ignored ----
        set_a(1, 5'd4, 1, 0, 0, 0, 2'b00);
        tick();
        ia.Stall_ext = 1; ia.Flush = 1;
        set_a(1, 5'd12, 1, 0, 5'd4, 0, 2'b01);
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("freeze c%0d sel0", c), 64'(a_sel(0)), 64'd1);
            tick();
        end
        ia.Stall_ext = 0; ia.Flush = 0;
        #1 check("after freeze sel0", 64'(a_sel(0)), 64'd1);
        tick();
        ia.Flush = 1;
        set_a(1, 5'd13, 1, 0, 5'd4, 0, 2'b01);
        #1 check("pre-flush sel0", 64'(a_sel(0)), 64'd2);
        tick();
        ia.Flush = 0;
        set_a(1, 5'd0, 0, 0, 5'd13, 5'd12, 2'b11);
        #1;
        check("flushed rd13", 64'(a_sel(0)), 64'd0);
        check("rd12 stage2", 64'(a_sel(1)), 64'd2);
        tick();
        set_a(0, 0, 0, 0, 0, 0, 2'b00);

        // ---- deep instance ----
        set_b(1, 5'd6, 1, 1, 0, 0, 0, 3'b000);
        tick();
        set_b(1, 5'd14, 1, 0, 5'd6, 0, 0, 3'b001);
        #1;
        check("b c1 stall", 64'(ib.Stall), 64'd1);
        check("b c1 sel0", 64'(b_sel(0)), 64'd1);
        tick();
        #1;
        check("b c2 stall", 64'(ib.Stall), 64'd1);
        check("b c2 sel0", 64'(b_sel(0)), 64'd2);
        tick();
        #1;
        check("b c3 stall", 64'(ib.Stall), 64'd0);
        check("b c3 sel0", 64'(b_sel(0)), 64'd3);
        tick();
        set_b(1, 5'd0, 0, 0, 5'd14, 0, 5'd6, 3'b101);
        #1;
        check("b stage4 sel2", 64'(b_sel(2)), 64'd4);
        check("b stage1 sel0", 64'(b_sel(0)), 64'd1);
        check("b stage4 stall", 64'(ib.Stall), 64'd0);
`ifdef FWD_STALL_CNT_EN
        check("b cnt", 64'(ib.Stall_cnt), 64'd2);
`else
        check("b cnt", 64'(ib.Stall_cnt), 64'd0);
`endif
        tick();
        set_b(0, 0, 0, 0, 0, 0, 0, 3'b000);
        tick();
        tick();
        @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
